mac_stream_feeder: RTL and testbench

- Transmit-side companion to the polynomial MAC.
- Holds a bank of input samples and a bank of series coefficients in local register storage, loaded by a host port.
- On start, streams all samples, then all coefficients, into the MAC's signal_fifo and coeff_fifo inputs, one word per cycle under FIFO-full backpressure.
- Each stream ends with the NaN terminator word 0x7F900000.

---
 rtl/mac_stream_feeder.sv | 164 ++++++++++++++++
 tb/tb_mac_stream_feeder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_feeder.sv
// mac_stream_feeder: holds a host-loaded sample bank and coefficient bank and,
// on start, streams the samples and then the coefficients into the polynomial
// MAC's two input FIFOs, one word per cycle, honouring each FIFO's full flag.
// A NaN terminator word closes each stream.
module mac_stream_feeder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_LINES = 5,
  parameter logic [DATA_WIDTH-1:0] TERM_WORD  = 32'h7F900000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_sig_we_i,
  input  logic                  load_coeff_we_i,
  input  logic [ADDR_LINES-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic [ADDR_LINES:0]   sig_count_i,
  input  logic [ADDR_LINES:0]   coeff_count_i,
  input  logic                  start_i,
  input  logic                  full_mul_i,
  input  logic                  full_adder_i,
  output logic [DATA_WIDTH-1:0] signal_fifo_o,
  output logic                  signal_valid_o,
  output logic [DATA_WIDTH-1:0] coeff_fifo_o,
  output logic                  coeff_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                DEPTH     = 1 << ADDR_LINES;
  localparam logic [ADDR_LINES:0] DEPTH_CNT = (ADDR_LINES+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SEND_SIG,
    TERM_SIG,
    SEND_COEFF,
    TERM_COEFF,
    DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_LINES:0]   idx_q;
  logic [ADDR_LINES:0]   idx_d;
  logic [ADDR_LINES:0]   sig_cnt_q;
  logic [ADDR_LINES:0]   sig_cnt_d;
  logic [ADDR_LINES:0]   coeff_cnt_q;
  logic [ADDR_LINES:0]   coeff_cnt_d;
  logic [DATA_WIDTH-1:0] sig_word_q;
  logic [DATA_WIDTH-1:0] coeff_word_q;
  logic                  sig_valid_q;
  logic                  coeff_valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] sig_bank   [DEPTH];
  logic [DATA_WIDTH-1:0] coeff_bank [DEPTH];
  logic [DATA_WIDTH-1:0] sig_rd;
  logic [DATA_WIDTH-1:0] coeff_rd;

  // Host loads land only while idle, so a running transfer always sees a stable bank.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE) begin
      if (load_sig_we_i) begin
        sig_bank[load_addr_i] <= load_data_i;
      end
      if (load_coeff_we_i) begin
        coeff_bank[load_addr_i] <= load_data_i;
      end
    end
  end

  // Counts above the bank depth clamp to a full bank; the index never wraps.
  always_comb begin
    sig_cnt_d   = (sig_count_i > DEPTH_CNT) ? DEPTH_CNT : sig_count_i;
    coeff_cnt_d = (coeff_count_i > DEPTH_CNT) ? DEPTH_CNT : coeff_count_i;
  end

  assign idx_d    = idx_q + 1'b1;
  assign sig_rd   = sig_bank[idx_q[ADDR_LINES-1:0]];
  assign coeff_rd = coeff_bank[idx_q[ADDR_LINES-1:0]];

  // Transfer sequencer: every output is a register; valids default low each edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      sig_cnt_q     <= '0;
      coeff_cnt_q   <= '0;
      sig_word_q    <= '0;
      coeff_word_q  <= '0;
      sig_valid_q   <= 1'b0;
      coeff_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      sig_valid_q   <= 1'b0;
      coeff_valid_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sig_cnt_q   <= sig_cnt_d;
            coeff_cnt_q <= coeff_cnt_d;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= (sig_cnt_d == '0) ? TERM_SIG : SEND_SIG;
          end
        end
        SEND_SIG: begin
          if (!full_mul_i) begin
            sig_word_q  <= sig_rd;
            sig_valid_q <= 1'b1;
            idx_q       <= idx_d;
            if (idx_d == sig_cnt_q) begin
              state_q <= TERM_SIG;
            end
          end
        end
        TERM_SIG: begin
          if (!full_mul_i) begin
            sig_word_q  <= TERM_WORD;
            sig_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= (coeff_cnt_q == '0) ? TERM_COEFF : SEND_COEFF;
          end
        end
        SEND_COEFF: begin
          if (!full_adder_i) begin
            coeff_word_q  <= coeff_rd;
            coeff_valid_q <= 1'b1;
            idx_q         <= idx_d;
            if (idx_d == coeff_cnt_q) begin
              state_q <= TERM_COEFF;
            end
          end
        end
        TERM_COEFF: begin
          if (!full_adder_i) begin
            coeff_word_q  <= TERM_WORD;
            coeff_valid_q <= 1'b1;
            idx_q         <= '0;
            state_q       <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign signal_fifo_o  = sig_word_q;
  assign signal_valid_o = sig_valid_q;
  assign coeff_fifo_o   = coeff_word_q;
  assign coeff_valid_o  = coeff_valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Bench for mac_stream_feeder: a transaction-level model predicts, for each
// transfer, which word appears on which stream at which clock edge, plus the
// busy window and the done edge; one checker compares every cycle.
module tb_mac_stream_feeder;

  localparam logic [31:0] TERM = 32'h7F900000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        load_sig_we_i = 1'b0;
  logic        load_coeff_we_i = 1'b0;
  logic [4:0]  load_addr_i = '0;
  logic [31:0] load_data_i = '0;
  logic [5:0]  sig_count_i = '0;
  logic [5:0]  coeff_count_i = '0;
  logic        start_i = 1'b0;
  logic        full_mul_i = 1'b0;
  logic        full_adder_i = 1'b0;
  logic [31:0] signal_fifo_o;
  logic        signal_valid_o;
  logic [31:0] coeff_fifo_o;
  logic        coeff_valid_o;
  logic        busy_o;
  logic        done_o;

  mac_stream_feeder dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .load_sig_we_i  (load_sig_we_i),
    .load_coeff_we_i(load_coeff_we_i),
    .load_addr_i    (load_addr_i),
    .load_data_i    (load_data_i),
    .sig_count_i    (sig_count_i),
    .coeff_count_i  (coeff_count_i),
    .start_i        (start_i),
    .full_mul_i     (full_mul_i),
    .full_adder_i   (full_adder_i),
    .signal_fifo_o  (signal_fifo_o),
    .signal_valid_o (signal_valid_o),
    .coeff_fifo_o   (coeff_fifo_o),
    .coeff_valid_o  (coeff_valid_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          edge_n;
  } item_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        rst_edge = 1'b0;
  item_t       exp_sig[$];
  item_t       exp_coeff[$];
  logic [31:0] cap_sig[$];
  logic [31:0] cap_coeff[$];
  logic [31:0] held_sig = '0;
  logic [31:0] held_coeff = '0;
  logic [31:0] model_sig[32];
  logic [31:0] model_coeff[32];
  int          busy_lo = 1;
  int          busy_hi = 0;
  int          done_at = -1;
  int          done_seen = -1;
  int          last_e0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: actual %h required %h", name, cyc, act, req);
    end
  endtask

  // Edge counter and reset-at-edge marker for the checker.
  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_edge = rst_i;
  end

  // Per-cycle checker against the predicted schedule.
  always @(negedge clk) begin
    logic ev_s;
    logic ev_c;
    if (cyc > 0) begin
      if (rst_edge) begin
        held_sig   = '0;
        held_coeff = '0;
      end
      ev_s = (exp_sig.size() > 0) && (exp_sig[0].edge_n == cyc);
      if (ev_s) begin
        held_sig = exp_sig[0].word;
        void'(exp_sig.pop_front());
      end
      ev_c = (exp_coeff.size() > 0) && (exp_coeff[0].edge_n == cyc);
      if (ev_c) begin
        held_coeff = exp_coeff[0].word;
        void'(exp_coeff.pop_front());
      end
      chk("signal_valid", {31'd0, signal_valid_o}, {31'd0, ev_s});
      chk("signal_word", signal_fifo_o, held_sig);
      chk("coeff_valid", {31'd0, coeff_valid_o}, {31'd0, ev_c});
      chk("coeff_word", coeff_fifo_o, held_coeff);
      chk("valid_exclusive", {31'd0, signal_valid_o & coeff_valid_o}, 32'd0);
      chk("busy", {31'd0, busy_o}, {31'd0, (cyc >= busy_lo) && (cyc <= busy_hi)});
      chk("done", {31'd0, done_o}, {31'd0, cyc == done_at});
      if (signal_valid_o) cap_sig.push_back(signal_fifo_o);
      if (coeff_valid_o) cap_coeff.push_back(coeff_fifo_o);
      if (done_o) done_seen = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] sig_pattern(input int k);
    logic [31:0] w;
    if (k == 0) w = 32'hC0A00000;
    else if (k == 29) w = 32'h40A00000;
    else if (k == 15) w = 32'h7F900000;
    else w = 32'h3E000000 + 32'(k) * 32'h1000;
    return w;
  endfunction

  function automatic logic [31:0] coeff_pattern(input int k);
    logic [31:0] w;
    if (k == 0) w = 32'h3493F27D;
    else if (k == 10) w = 32'h3F800000;
    else w = 32'h3A000000 + 32'(k) * 32'h20000;
    return w;
  endfunction

  task automatic load_all();
    for (int i = 0; i < 32; i++) begin
      load_sig_we_i   = 1'b1;
      load_coeff_we_i = 1'b1;
      load_addr_i     = 5'(i);
      load_data_i     = sig_pattern(i);
      model_sig[i]    = sig_pattern(i);
      model_coeff[i]  = coeff_pattern(i);
      // Same cycle drives both banks only when data match, so split the coefficient write.
      load_coeff_we_i = 1'b0;
      step();
      load_sig_we_i   = 1'b0;
      load_coeff_we_i = 1'b1;
      load_data_i     = coeff_pattern(i);
      step();
    end
    load_sig_we_i   = 1'b0;
    load_coeff_we_i = 1'b0;
    load_data_i     = '0;
    step();
  endtask

  // One transfer. Windows and event positions are edge offsets from the edge
  // that samples start_i; an empty window has lo > hi.
  task automatic run(input int sn, input int cn,
                     input int mul_lo, input int mul_hi,
                     input int add_lo, input int add_hi,
                     input int abort_at, input int poke_at, input bit poke_done);
    int e0;
    int e;
    int ns;
    int ncf;
    int end_edge;
    int rel;
    int done_rel;
    item_t it;
    e0 = cyc + 1;
    last_e0 = e0;
    ns  = (sn > 32) ? 32 : sn;
    ncf = (cn > 32) ? 32 : cn;
    cap_sig.delete();
    cap_coeff.delete();
    done_seen = -1;
    e = e0 + 1;
    for (int k = 0; k <= ns; k++) begin
      while (e >= e0 + mul_lo && e <= e0 + mul_hi) e++;
      it.word = (k < ns) ? model_sig[k] : TERM;
      it.edge_n = e;
      if (abort_at < 0 || e < e0 + abort_at) exp_sig.push_back(it);
      e++;
    end
    for (int k = 0; k <= ncf; k++) begin
      while (e >= e0 + add_lo && e <= e0 + add_hi) e++;
      it.word = (k < ncf) ? model_coeff[k] : TERM;
      it.edge_n = e;
      if (abort_at < 0 || e < e0 + abort_at) exp_coeff.push_back(it);
      e++;
    end
    done_rel = e - e0;
    busy_lo = e0;
    if (abort_at >= 0) begin
      busy_hi  = e0 + abort_at - 1;
      done_at  = -1;
      end_edge = e0 + abort_at + 2;
    end else begin
      busy_hi  = e - 1;
      done_at  = e;
      end_edge = e + 2;
    end
    start_i       = 1'b1;
    sig_count_i   = 6'(sn);
    coeff_count_i = 6'(cn);
    while (cyc < end_edge) begin
      step();
      rel = cyc + 1 - e0;
      full_mul_i   = (rel >= mul_lo) && (rel <= mul_hi);
      full_adder_i = (rel >= add_lo) && (rel <= add_hi);
      rst_i        = (abort_at >= 0) && (rel == abort_at);
      if ((rel == poke_at) || (poke_done && rel == done_rel)) begin
        start_i         = 1'b1;
        load_sig_we_i   = 1'b1;
        load_coeff_we_i = 1'b1;
        load_addr_i     = 5'd0;
        load_data_i     = 32'hDEADBEEF;
      end else begin
        start_i         = 1'b0;
        load_sig_we_i   = 1'b0;
        load_coeff_we_i = 1'b0;
        load_data_i     = '0;
      end
    end
    start_i = 1'b0; full_mul_i = 1'b0; full_adder_i = 1'b0; rst_i = 1'b0;
    load_sig_we_i = 1'b0; load_coeff_we_i = 1'b0;
    step();
    chk("sig_words_outstanding", 32'(exp_sig.size()), 32'd0);
    chk("coeff_words_outstanding", 32'(exp_coeff.size()), 32'd0);
    $display("transfer sig=%0d coeff=%0d abort=%0d: sent %0d sig, %0d coeff words, done edge offset %0d",
             sn, cn, abort_at, cap_sig.size(), cap_coeff.size(),
             (done_seen < 0) ? -1 : done_seen - e0 + 1);
  endtask

  initial begin
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    repeat (3) step();

    // Zero counts: two terminators only; done four cycles after start.
    run(0, 0, 1, 0, 1, 0, -1, -1, 1'b0);
    chk("zero_done_latency", 32'(done_seen - last_e0 + 1), 32'd4);
    chk("zero_sig_len", 32'(cap_sig.size()), 32'd1);
    if (cap_sig.size() > 0) chk("zero_sig_term", cap_sig[0], 32'h7F900000);
    chk("zero_coeff_len", 32'(cap_coeff.size()), 32'd1);

    load_all();

    // Basic transfer with a start/load poke mid-stream and a start in the DONE cycle.
    run(30, 11, 1, 0, 1, 0, -1, 10, 1'b1);
    chk("basic_done_latency", 32'(done_seen - last_e0 + 1), 32'd45);
    chk("basic_sig_len", 32'(cap_sig.size()), 32'd31);
    chk("basic_coeff_len", 32'(cap_coeff.size()), 32'd12);
    if (cap_sig.size() == 31) begin
      chk("basic_sig_first", cap_sig[0], 32'hC0A00000);
      chk("basic_sig_nan_data", cap_sig[15], 32'h7F900000);
      chk("basic_sig_last", cap_sig[29], 32'h40A00000);
      chk("basic_sig_term", cap_sig[30], 32'h7F900000);
    end
    if (cap_coeff.size() == 12) begin
      chk("basic_coeff_first", cap_coeff[0], 32'h3493F27D);
      chk("basic_coeff_last", cap_coeff[10], 32'h3F800000);
      chk("basic_coeff_term", cap_coeff[11], 32'h7F900000);
    end

    // Backpressure: three stalled edges after sample 4 and after coefficient 4.
    run(30, 11, 6, 8, 40, 42, -1, -1, 1'b0);
    chk("bp_done_latency", 32'(done_seen - last_e0 + 1), 32'd51);
    if (cap_sig.size() > 5) chk("bp_sig_bank_kept", cap_sig[0], 32'hC0A00000);

    // Full flags of the inactive phase must be ignored.
    run(8, 6, 12, 14, 3, 6, -1, -1, 1'b0);
    chk("noise_done_latency", 32'(done_seen - last_e0 + 1), 32'd18);

    // Abort at sample 10, then a fresh start replays from sample 0.
    run(30, 11, 1, 0, 1, 0, 11, -1, 1'b0);
    chk("abort_sig_len", 32'(cap_sig.size()), 32'd10);
    chk("abort_no_done", 32'(done_seen), 32'hFFFFFFFF);
    run(30, 11, 1, 0, 1, 0, -1, -1, 1'b0);
    if (cap_sig.size() > 0) chk("replay_first", cap_sig[0], 32'hC0A00000);

    // Oversized counts clamp to a full bank.
    run(40, 40, 1, 0, 1, 0, -1, -1, 1'b0);
    chk("sat_sig_len", 32'(cap_sig.size()), 32'd33);
    chk("sat_coeff_len", 32'(cap_coeff.size()), 32'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
